nibble_serial_adder_seq: RTL and testbench

- Sequencer that performs a WIDTH-bit addition 4 bits per cycle through the team's 4-bit carry-lookahead adder slice.
- Sits upstream of that slice: drives its a/b/cin inputs and consumes its 5-bit sum output.
- Recirculates the slice carry between nibbles.
- Exposes valid/ready handshakes on the operand and result sides.

---
 rtl/nibble_serial_adder_seq.sv | 162 ++++++++++++++++
 tb/tb_nibble_serial_adder_seq.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_seq.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder_seq
//
// Performs a WIDTH-bit addition four bits per cycle through an external 4-bit
// carry-lookahead adder slice. The block drives the slice inputs and takes the
// 5-bit slice result back in the same cycle. The slice carry is carried from
// one nibble to the next in a register.
//
// Operands are accepted with a valid/ready handshake. The result is returned
// with a valid/ready handshake. One operation is in flight at a time. An
// operation moves through IDLE (accept), RUN (one slice pass per nibble) and
// DONE (result held until taken).
//
// Optional feature: when NIBBLE_SERIAL_ADDER_SUB_EN is defined, the block has
// an extra op_sub input. When op_sub is 1, the block computes op_a - op_b.
// cout_out = 1 means no borrow.
//
// Parameters:
//   WIDTH      operand/result width; a multiple of 4, >= 4
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operand pair valid          in_ready   block can accept
//   op_a/op_b  addends                      op_cin     carry into nibble 0
//   op_sub     subtract select (optional build only)
//   out_valid  result valid                 out_ready  consumer takes result
//   sum_out    result                       cout_out   carry out of top nibble
//   add_a/add_b/add_cin  nibble operands to the adder slice (0 outside RUN)
//   add_sum    slice result: [3:0] sum, [4] carry out
// -----------------------------------------------------------------------------
module nibble_serial_adder_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [4:0]       add_sum
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, sum_q;
  logic             carry_q, cout_q;
  logic [CNT_W-1:0] cnt;

  logic             accept, last_pass;
  logic [WIDTH-1:0] b_load;
  logic             cin_load;

  // Operand B and the initial carry that are loaded at accept.
  // Subtraction is computed as a + ~b + 1.
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  assign b_load   = op_sub ? ~op_b : op_b;
  assign cin_load = op_sub ? 1'b1  : op_cin;
`else
  assign b_load   = op_b;
  assign cin_load = op_cin;
`endif

  // Next-state logic and all state-derived outputs.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path leaves one
    // unassigned and no latch is inferred.
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = 4'h0;
    add_b     = 4'h0;
    add_cin   = 1'b0;
    accept    = 1'b0;
    last_pass = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        add_a   = a_sh[3:0];
        add_b   = b_sh[3:0];
        add_cin = carry_q;
        if (cnt == LAST) begin
          last_pass = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        // DONE never asserts in_ready, so a result handshake and an operand
        // accept cannot happen on the same edge.
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state is written with non-blocking assignments. All
    // flops then update together at the edge, and the order of the
    // statements does not matter.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the datapath registers are reset along with the FSM. sum_out
      // and cout_out must read 0 after reset. An aborted operation must not
      // leave a partial sum visible.
      a_sh    <= '0;
      b_sh    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt     <= '0;
    end else if (accept) begin
      a_sh    <= op_a;
      b_sh    <= b_load;
      carry_q <= cin_load;
      cnt     <= '0;
    end else if (state_q == RUN) begin
      // The slice result enters at the top of the sum register. After NIBBLES
      // passes, the first nibble computed has reached bits [3:0].
      sum_q   <= (sum_q >> 4) | (WIDTH'(add_sum[3:0]) << (WIDTH - 4));
      carry_q <= add_sum[4];
      a_sh    <= a_sh >> 4;
      b_sh    <= b_sh >> 4;
      cnt     <= cnt + CNT_W'(1);
      if (last_pass) cout_q <= add_sum[4];
    end
  end

  assign sum_out  = sum_q;
  assign cout_out = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder_seq.sv
// -----------------------------------------------------------------------------
// Self-checking bench for nibble_serial_adder_seq (WIDTH = 16).
// The external 4-bit adder slice is modelled here as a plain 5-bit addition.
// A transaction-level reference model is checked against the DUT on every
// falling edge. The model computes each result as a + b + cin and derives
// the expected per-pass slice inputs from the operands. Directed cases pin
// the model with literal expectations. A randomized run follows them.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder_seq;

  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a, op_b;
  logic             op_cin;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  logic             op_sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum_out;
  logic             cout_out;
  logic [3:0]       add_a, add_b;
  logic             add_cin;
  logic [4:0]       add_sum;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  // Adder slice model: combinational return within the same cycle.
  assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  nibble_serial_adder_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_cin    (op_cin),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    .op_sub    (op_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .cout_out  (cout_out),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  //   m_pass : -1 waiting for operands, 0..NIBBLES-1 slice pass, NIBBLES result
  // ---------------------------------------------------------------------------
  int               m_pass = -1;
  bit               m_after_reset = 1'b1;
  logic [WIDTH-1:0] m_a, m_b;
  logic             m_cin;
  logic [WIDTH:0]   m_res;
  int               cyc = 0;
  int               acc_cyc[$];
  int               hs_cyc[$];
  logic [WIDTH:0]   res_q[$];
  logic [NIBBLES-1:0] cin_seq;
  logic [WIDTH-1:0] a_seq;

  function automatic logic carry_into(int k);
    longint lo, s;
    lo = (longint'(1) << (4 * k)) - 1;
    s  = (longint'(m_a) & lo) + (longint'(m_b) & lo) + longint'(m_cin);
    return s[4 * k];
  endfunction

  always @(negedge clk) begin
    if (started) begin
      check("in_ready", in_ready, m_pass < 0);
      check("out_valid", out_valid, m_pass == NIBBLES);
      if (m_pass == NIBBLES) begin
        check("sum_out", sum_out, m_res[WIDTH-1:0]);
        check("cout_out", cout_out, m_res[WIDTH]);
      end
      if (m_after_reset) begin
        check("reset_sum", sum_out, 0);
        check("reset_cout", cout_out, 0);
      end
      if (m_pass >= 0 && m_pass < NIBBLES) begin
        check("add_a", add_a, (m_a >> (4 * m_pass)) & 16'hF);
        check("add_b", add_b, (m_b >> (4 * m_pass)) & 16'hF);
        check("add_cin", add_cin, carry_into(m_pass));
        cin_seq[m_pass] = add_cin;
        a_seq[4 * m_pass +: 4] = add_a;
      end else begin
        check("add_a_idle", add_a, 0);
        check("add_b_idle", add_b, 0);
        check("add_cin_idle", add_cin, 0);
      end
    end
    // Advance the model with the inputs that the next rising edge will sample.
    cyc++;
    m_after_reset = 1'b0;
    if (!rst_n) begin
      m_pass = -1;
      m_after_reset = 1'b1;
    end else if (m_pass < 0) begin
      if (in_valid) begin
        m_a   = op_a;
        m_b   = op_b;
        m_cin = op_cin;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        if (op_sub) begin
          m_b   = ~op_b;
          m_cin = 1'b1;
        end
`endif
        m_res = {1'b0, m_a} + {1'b0, m_b} + {{WIDTH{1'b0}}, m_cin};
        acc_cyc.push_back(cyc);
        m_pass = 0;
      end
    end else if (m_pass < NIBBLES) begin
      m_pass++;
    end else if (out_ready) begin
      hs_cyc.push_back(cyc);
      res_q.push_back({cout_out, sum_out});
      m_pass = -1;
    end
  end

  // ---------------------------------------------------------------------------
  // One operation: present operands, wait for the result, optionally stall the
  // result for 'hold' cycles, then take it. lat counts edges from accept
  // (inclusive) to the first cycle with out_valid.
  // ---------------------------------------------------------------------------
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input int hold,
                        output logic [WIDTH-1:0] s, output logic c, output int lat);
    int n;
    op_a = a; op_b = b; op_cin = cin; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) check("accept_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble the operand bus; the captured operands must be unaffected.
    op_a = WIDTH'($urandom); op_b = WIDTH'($urandom); op_cin = 1'($urandom);
    lat = 1; n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; lat++; n++;
    end
    if (!out_valid) check("result_timeout", out_valid, 1);
    s = sum_out;
    c = cout_out;
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_sum", sum_out, s);
      check("hold_cout", cout_out, c);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_after_take", in_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [WIDTH-1:0] s;
    logic             c;
    int               lat;
    int               n;
    logic [WIDTH:0]   exp_full;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; op_cin = 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    op_sub = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    started = 1'b1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum_out, 0);
    check("rst_cout", cout_out, 0);
    check("rst_add_a", add_a, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 0x1234 + 0x4321
    run_op(16'h1234, 16'h4321, 1'b0, 0, s, c, lat);
    check("t1_sum", s, 16'h5555);
    check("t1_cout", c, 0);
    check("t1_latency", lat, 5);
    check("t1_cin_seq", cin_seq, 4'b0000);
    check("t1_a_seq", a_seq, 16'h1234);

    // 0xFFFF + 0x0001: the carry ripples through every nibble
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, s, c, lat);
    check("t2_sum", s, 16'h0000);
    check("t2_cout", c, 1);
    check("t2_cin_seq", cin_seq, 4'b1110);

    // 0x0000 + 0xFFFF + 1, with the result stalled for 3 cycles
    run_op(16'h0000, 16'hFFFF, 1'b1, 3, s, c, lat);
    check("t3_sum", s, 16'h0000);
    check("t3_cout", c, 1);

    // Reset during the second slice pass discards the operation
    op_a = 16'hABCD; op_b = 16'h1111; op_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("t4_in_ready", in_ready, 1);
    check("t4_out_valid", out_valid, 0);
    check("t4_sum", sum_out, 0);
    check("t4_add_a", add_a, 0);
    check("t4_add_b", add_b, 0);
    run_op(16'h0001, 16'h0001, 1'b0, 0, s, c, lat);
    check("t4_after_sum", s, 16'h0002);
    check("t4_after_cout", c, 0);

    // Back-to-back: in_valid stays high across two operations
    acc_cyc.delete(); hs_cyc.delete(); res_q.delete();
    op_a = 16'h00FF; op_b = 16'h0001; op_cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    op_a = 16'h8000; op_b = 16'h8000;
    n = 0;
    while (res_q.size() < 2 && n < 60) begin
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("t5_results", res_q.size(), 2);
    if (res_q.size() >= 2 && acc_cyc.size() >= 2 && hs_cyc.size() >= 1) begin
      check("t5_res0", res_q[0], 17'h0_0100);
      check("t5_res1", res_q[1], 17'h1_0000);
      check("t5_accept_gap", acc_cyc[1] - hs_cyc[0], 1);
    end
    @(posedge clk); #1;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    op_sub = 1'b1;
    run_op(16'h0005, 16'h0007, 1'b0, 0, s, c, lat);
    check("sub1_sum", s, 16'hFFFE);
    check("sub1_cout", c, 0);
    op_sub = 1'b1;
    run_op(16'h0007, 16'h0005, 1'b1, 0, s, c, lat);
    check("sub2_sum", s, 16'h0002);
    check("sub2_cout", c, 1);
    op_sub = 1'b0;
`endif

    // Randomized operations with idle gaps and random result stalls
    for (int i = 0; i < 150; i++) begin
      logic [WIDTH-1:0] ra, rb;
      logic             rc;
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      if (i % 10 == 0) ra = '1;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
      op_sub = 1'($urandom);
      if (op_sub) exp_full = {1'b0, ra} + {1'b0, ~rb} + 17'd1;
      else        exp_full = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
`else
      exp_full = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
`endif
      run_op(ra, rb, rc, $urandom_range(0, 2), s, c, lat);
      check("rand_result", {c, s}, exp_full);
      check("rand_latency", lat, NIBBLES + 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
